// File: rtl/wfifo_burst_sched_pkg.sv
// wfifo_burst_sched_pkg
// Shared definitions for the write-FIFO burst scheduler and its SDRAM-side
// peers: FSM state encoding, burst length field width, and the default burst
// length / ring end address agreed with the SDRAM controller.
package wfifo_burst_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  // wr_len must hold up to 256 words.
  localparam int LEN_W = 9;

  localparam int          DEF_BURST_LEN = 8;
  localparam logic [23:0] DEF_ADDR_MAX  = 24'h00FFFF;

endpackage

// File: rtl/wfifo_burst_sched_if.sv
// wfifo_burst_sched_if
// Bundles the write-FIFO read side and the SDRAM controller write port as seen
// by the burst scheduler.
//   master : the scheduler (drives wfifo_rd_en, wr_req, wr_addr, wr_len)
//   slave  : FIFO / SDRAM controller side (drives wfifo_rd_cnt, wr_ack,
//            wr_data_req, wr_done)
interface wfifo_burst_sched_if
  import wfifo_burst_sched_pkg::*;
#(
  parameter int FIFO_CNT_W = 10,
  parameter int ADDR_W     = 24
);
  logic [FIFO_CNT_W-1:0] wfifo_rd_cnt;
  logic                  wfifo_rd_en;
  logic                  wr_req;
  logic                  wr_ack;
  logic                  wr_data_req;
  logic                  wr_done;
  logic [ADDR_W-1:0]     wr_addr;
  logic [LEN_W-1:0]      wr_len;

  modport master (
    input  wfifo_rd_cnt, wr_ack, wr_data_req, wr_done,
    output wfifo_rd_en, wr_req, wr_addr, wr_len
  );

  modport slave (
    output wfifo_rd_cnt, wr_ack, wr_data_req, wr_done,
    input  wfifo_rd_en, wr_req, wr_addr, wr_len
  );
endinterface

// File: rtl/wfifo_burst_sched_addr_ring.sv
// wfifo_addr_ring
// SDRAM write address ring for the burst scheduler. Holds the burst start
// address, advances it by the finished burst length, and wraps to ADDR_BASE
// when the following full burst would run past ADDR_MAX.
//   clk, rst_n : clock, async active-low reset
//   step_i     : high for the single DONE cycle; advance (or clear) the address
//   idle_i     : scheduler is in IDLE; addr_clr acts immediately
//   clr_i      : restart request; deferred to the next step when not idle
//   len_i      : length of the burst just completed
//   addr_o     : current burst start address
//   wrap_o     : one-cycle pulse after a wrap-around step
module wfifo_addr_ring
  import wfifo_burst_sched_pkg::*;
#(
  parameter int                ADDR_W    = 24,
  parameter int                BURST_LEN = DEF_BURST_LEN,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(DEF_ADDR_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_i,
  input  logic              idle_i,
  input  logic              clr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wrap_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W:0]   next_w;
  logic [ADDR_W:0]   last_w;

  // One extra bit so an address sum past the top of the space is still seen
  // as exceeding ADDR_MAX instead of aliasing low.
  assign next_w = {1'b0, addr_q} + (ADDR_W+1)'(len_i);
  assign last_w = next_w + (ADDR_W+1)'(BURST_LEN - 1);

  always_comb begin
    addr_d = addr_q;
    pend_d = pend_q;
    wrap_d = 1'b0;
    if (step_i) begin
      pend_d = 1'b0;
      // A pending (or same-cycle) clear wins over the increment and is not a wrap.
      if (clr_i || pend_q) begin
        addr_d = ADDR_BASE;
      end else if (last_w > {1'b0, ADDR_MAX}) begin
        addr_d = ADDR_BASE;
        wrap_d = 1'b1;
      end else begin
        addr_d = next_w[ADDR_W-1:0];
      end
    end else if (clr_i) begin
      if (idle_i) addr_d = ADDR_BASE;
      else        pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= ADDR_BASE;
      pend_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      pend_q <= pend_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr_o = addr_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/wfifo_burst_sched.sv
// wfifo_burst_sched
// Write-side scheduler between the UART packer's word FIFO and the SDRAM
// controller write port. Requests a burst once BURST_LEN words are buffered,
// strobes the FIFO read for each data beat the controller asks for, and steps
// the ring address after each burst.
//   clk, rst_n : clock, async active-low reset
//   bus        : wfifo_burst_sched_if.master (FIFO count/read, SDRAM write port)
//   addr_clr   : pulse, restart the address at ADDR_BASE
//   busy       : scheduler is not IDLE
//   addr_wrap  : one-cycle pulse when the address wraps
//   burst_err  : sticky; wr_done with a short beat count, or outside a burst
// Optional feature macro WFIFO_FLUSH_TIMEOUT_EN: after TIMEOUT_CYC idle cycles
// with a sub-burst residue in the FIFO, flush it as a partial burst.
module wfifo_burst_sched
  import wfifo_burst_sched_pkg::*;
#(
  parameter int                BURST_LEN   = DEF_BURST_LEN,
  parameter int                FIFO_CNT_W  = 10,
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = '0,
  parameter logic [ADDR_W-1:0] ADDR_MAX    = ADDR_W'(DEF_ADDR_MAX),
  parameter int                TIMEOUT_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wfifo_burst_sched_if.master  bus,
  input  logic                 addr_clr,
  output logic                 busy,
  output logic                 addr_wrap,
  output logic                 burst_err
);

  localparam logic [FIFO_CNT_W:0] BURST_CNT = (FIFO_CNT_W+1)'(BURST_LEN);
  localparam logic [LEN_W-1:0]    BURST_L   = LEN_W'(BURST_LEN);

  state_t           state_q, state_d;
  logic             wr_req_q, wr_req_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             err_q, err_d;
  logic             rd_en;
  logic             full_avail;
  logic             tmo_hit;

  assign full_avail = {1'b0, bus.wfifo_rd_cnt} >= BURST_CNT;

`ifdef WFIFO_FLUSH_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
  logic        residue;

  assign residue = (bus.wfifo_rd_cnt != '0) && !full_avail;
  assign tmo_hit = (state_q == IDLE) && residue && (idle_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_d = idle_q + 16'd1;
    if ((state_q != IDLE) || !residue || tmo_hit) idle_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Combinational so the FIFO word appears in the same cycle the controller asks.
  assign rd_en = (state_q == BURST) && bus.wr_data_req && (beat_q < len_q);

  always_comb begin
    state_d  = state_q;
    wr_req_d = wr_req_q;
    len_d    = len_q;
    beat_d   = beat_q;
    err_d    = err_q;
    if (rd_en) beat_d = beat_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_done) err_d = 1'b1;
        if (full_avail) begin
          len_d    = BURST_L;
          wr_req_d = 1'b1;
          state_d  = REQ;
        end else if (tmo_hit) begin
          len_d    = LEN_W'(bus.wfifo_rd_cnt);
          wr_req_d = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (bus.wr_done) err_d = 1'b1;
        if (bus.wr_ack) begin
          wr_req_d = 1'b0;
          beat_d   = '0;
          state_d  = BURST;
        end
      end
      BURST: begin
        if (bus.wr_done) begin
          // Count includes a beat taken in the same cycle as wr_done.
          if (beat_d != len_q) err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_req_q <= 1'b0;
      len_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_req_q <= wr_req_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  wfifo_addr_ring #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_MAX  (ADDR_MAX)
  ) u_ring (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (state_q == DONE),
    .idle_i (state_q == IDLE),
    .clr_i  (addr_clr),
    .len_i  (len_q),
    .addr_o (bus.wr_addr),
    .wrap_o (addr_wrap)
  );

  assign bus.wfifo_rd_en = rd_en;
  assign bus.wr_req      = wr_req_q;
  assign bus.wr_len      = len_q;
  assign busy            = (state_q != IDLE);
  assign burst_err       = err_q;

endmodule

// File: tb/tb_wfifo_burst_sched.sv
module tb_wfifo_burst_sched;
  import wfifo_burst_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic addr_clr = 1'b0;
  logic busy, addr_wrap, burst_err;

  always #5 clk = ~clk;

  wfifo_burst_sched_if #(.FIFO_CNT_W(10), .ADDR_W(24)) bus();

  wfifo_burst_sched #(
    .BURST_LEN   (8),
    .FIFO_CNT_W  (10),
    .ADDR_W      (24),
    .ADDR_BASE   (24'd0),
    .ADDR_MAX    (24'd15),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .addr_clr  (addr_clr),
    .busy      (busy),
    .addr_wrap (addr_wrap),
    .burst_err (burst_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int n_req;     // wr_data_req pulses driven
    bit clr;       // pulse addr_clr during the burst
    int exp_rd;    // expected wfifo_rd_en count
    int exp_addr;  // expected wr_addr after DONE
    bit exp_wrap;  // expected addr_wrap pulse
    bit exp_err;   // expected burst_err after DONE
  } vec_t;

  typedef struct {
    logic [23:0] addr;
    logic [8:0]  len;
  } req_t;

  req_t        sb[$];
  logic [23:0] m_addr;
  vec_t        vecs[5];

  task automatic wait_req(input int limit, output int cycles);
    cycles = 0;
    while (!bus.wr_req && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Compare the request against the scoreboard; returns 0 if no request came.
  task automatic take_req(input string tag, output bit ok);
    int   cyc;
    req_t r;
    wait_req(300, cyc);
    ok = bus.wr_req;
    if (!ok) begin
      chk({tag, "_req_timeout"}, 0, 1);
      sb.delete();
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    r = sb.pop_front();
    chk({tag, "_addr"}, bus.wr_addr, r.addr);
    chk({tag, "_len"}, bus.wr_len, r.len);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic do_ack(input string tag);
    bus.wr_ack = 1'b1;
    @(negedge clk);
    bus.wr_ack = 1'b0;
    chk({tag, "_req_drop"}, bus.wr_req, 0);
  endtask

  task automatic beats(input int n, input bit clr, output int rd);
    rd = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.wr_data_req = 1'b1;
      addr_clr = clr && (i == 2);
      #1;
      if (bus.wfifo_rd_en === 1'b1) rd++;
    end
    @(negedge clk);
    bus.wr_data_req = 1'b0;
    addr_clr = 1'b0;
  endtask

  task automatic finish_burst(input string tag, input int exp_addr, input bit exp_wrap, input bit exp_err);
    bus.wr_done = 1'b1;
    @(negedge clk);
    bus.wr_done = 1'b0;
    chk({tag, "_err"}, burst_err, exp_err);
    @(negedge clk);
    chk({tag, "_next_addr"}, bus.wr_addr, exp_addr);
    chk({tag, "_wrap"}, addr_wrap, exp_wrap);
    chk({tag, "_idle"}, busy, 0);
    @(negedge clk);
    chk({tag, "_wrap_clear"}, addr_wrap, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit          ok;
    int          rd;
    logic [24:0] nxt;
    string       tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    bus.wfifo_rd_cnt = 10'd8;
    sb.push_back('{m_addr, 9'd8});
    @(negedge clk);
    chk({tag, "_req_latency"}, bus.wr_req, 1);
    take_req(tag, ok);
    bus.wfifo_rd_cnt = 10'd0;
    if (!ok) return;
    do_ack(tag);
    beats(v.n_req, v.clr, rd);
    chk({tag, "_rd_en_count"}, rd, v.exp_rd);
    finish_burst(tag, v.exp_addr, v.exp_wrap, v.exp_err);
    // Ring model for the next scoreboard entry.
    nxt = {1'b0, m_addr} + 25'd8;
    if (v.clr || (nxt + 25'd7 > 25'd15)) m_addr = 24'd0;
    else                                   m_addr = nxt[23:0];
  endtask

  initial begin
    bit ok;
    int rd;
    int cyc;

    bus.wfifo_rd_cnt = '0;
    bus.wr_ack       = 1'b0;
    bus.wr_data_req  = 1'b0;
    bus.wr_done      = 1'b0;
    m_addr           = 24'd0;

    // Start address 0 -> 8; 8 -> wrap; 0 -> 8; clr at 8 -> 0; short burst at 0.
    vecs[0] = '{n_req: 8,  clr: 0, exp_rd: 8, exp_addr: 8, exp_wrap: 0, exp_err: 0};
    vecs[1] = '{n_req: 12, clr: 0, exp_rd: 8, exp_addr: 0, exp_wrap: 1, exp_err: 0};
    vecs[2] = '{n_req: 8,  clr: 0, exp_rd: 8, exp_addr: 8, exp_wrap: 0, exp_err: 0};
    vecs[3] = '{n_req: 8,  clr: 1, exp_rd: 8, exp_addr: 0, exp_wrap: 0, exp_err: 0};
    vecs[4] = '{n_req: 5,  clr: 0, exp_rd: 5, exp_addr: 8, exp_wrap: 0, exp_err: 1};

    #1;
    chk("rst_wr_req", bus.wr_req, 0);
    chk("rst_rd_en", bus.wfifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", addr_wrap, 0);
    chk("rst_err", burst_err, 0);
    chk("rst_addr", bus.wr_addr, 0);
    chk("rst_len", bus.wr_len, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Below-threshold count must not start a burst.
    bus.wfifo_rd_cnt = 10'd7;
    repeat (3) @(negedge clk);
    chk("below_thresh_no_req", bus.wr_req, 0);
    bus.wfifo_rd_cnt = 10'd0;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    repeat (5) @(negedge clk);
    chk("err_sticky", burst_err, 1);

    // Reset asserted in the middle of a burst.
    bus.wfifo_rd_cnt = 10'd8;
    sb.push_back('{m_addr, 9'd8});
    take_req("rstmid", ok);
    bus.wfifo_rd_cnt = 10'd0;
    if (ok) begin
      do_ack("rstmid");
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        bus.wr_data_req = 1'b1;
      end
      rst_n = 1'b0;
      #1;
      chk("rstmid_rd_en", bus.wfifo_rd_en, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_err", burst_err, 0);
      chk("rstmid_addr", bus.wr_addr, 0);
      chk("rstmid_len", bus.wr_len, 0);
      chk("rstmid_wr_req", bus.wr_req, 0);
      bus.wr_data_req = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_addr = 24'd0;
    sb.delete();

    // Residue of 3 words held in the FIFO.
    @(negedge clk);
    bus.wfifo_rd_cnt = 10'd3;
`ifdef WFIFO_FLUSH_TIMEOUT_EN
    sb.push_back('{m_addr, 9'd3});
    wait_req(300, cyc);
    chk("tmo_cycles", cyc, 100);
    take_req("tmo", ok);
    bus.wfifo_rd_cnt = 10'd0;
    if (ok) begin
      do_ack("tmo");
      beats(3, 1'b0, rd);
      chk("tmo_rd_en_count", rd, 3);
      finish_burst("tmo", 3, 1'b0, 1'b0);
    end
`else
    wait_req(300, cyc);
    chk("no_tmo_wr_req", bus.wr_req, 0);
    chk("no_tmo_busy", busy, 0);
    bus.wfifo_rd_cnt = 10'd0;
`endif

    // Stray wr_done while idle flags an error.
    @(negedge clk);
    bus.wr_done = 1'b1;
    @(negedge clk);
    bus.wr_done = 1'b0;
    chk("idle_done_err", burst_err, 1);
    chk("idle_done_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
